// File: rtl/vme_mem_master.sv
// Single-outstanding VME-style bus initiator: command port in, one strobe out, done in, response port out.
// Optional WAIT-state timeout is compiled in with `define VME_MASTER_TIMEOUT_EN.
module vme_mem_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_mem,
    output logic                  mem_wr_mem,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_done,
    input  logic                  mem_wr_done
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic   is_write;
    logic   accept;
    logic   done_match;
    logic   expired;

    assign accept     = req_valid & req_ready;
    assign done_match = is_write ? mem_wr_done : mem_rd_done;

`ifdef VME_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    // Expiry is flagged in the last WAIT cycle, so a done arriving then still wins.
    assign expired = (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state == STROBE)
            wait_cnt <= '0;
        else if (state == WAIT)
            wait_cnt <= wait_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rsp_err <= 1'b0;
        else if (state == WAIT && done_match)
            rsp_err <= 1'b0;
        else if (state == WAIT && expired)
            rsp_err <= 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign expired        = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = STROBE;
            STROBE:  state_nxt = WAIT;
            WAIT:    if (done_match || expired) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Strobes are registered off the accept, so they are high only in STROBE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_write    <= 1'b0;
            mem_rd_mem  <= 1'b0;
            mem_wr_mem  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            rsp_rdata   <= '0;
        end else begin
            mem_rd_mem <= accept & ~req_write;
            mem_wr_mem <= accept & req_write;
            if (accept) begin
                is_write <= req_write;
                mem_addr <= req_addr;
                if (req_write)
                    mem_wr_data <= req_wdata;
            end
            if (state == WAIT && done_match)
                rsp_rdata <= is_write ? '0 : mem_rd_data;
            else if (state == WAIT && expired)
                rsp_rdata <= '0;
        end
    end

endmodule

// File: doc/vme_mem_master.md
# vme_mem_master

Bus initiator for the VME-style memory interface (addr / wr-data / rd-mem / wr-mem strobes, rd-data / rd-done / wr-done returns) used by the generated register banks. It accepts single read or write requests from an internal valid/ready command port and drives one strobe per request. It waits for the matching done, then returns the data and an error flag on a valid/ready response port. It is used by on-chip sequencers and test harnesses to access register banks without a real VME crate.

## Interface
- ADDR_WIDTH, 8, word-address width of req_addr / mem_addr
- DATA_WIDTH, 16, data width
- TIMEOUT, 255, maximum WAIT cycles before error (≥1; only used with timeout compiled in)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  1 = timeout
- mem_addr  out  ADDR_WIDTH  bus address
- mem_wr_data  out  DATA_WIDTH  bus write data
- mem_rd_mem  out  1  read strobe, one-cycle pulse
- mem_wr_mem  out  1  write strobe, one-cycle pulse
- mem_rd_data  in  DATA_WIDTH  responder read data, valid in the cycle mem_rd_done=1
- mem_rd_done  in  1  read acknowledge
- mem_wr_done  in  1  write acknowledge

## Operation
- FSM states: IDLE, STROBE, WAIT, RESP. Reset → IDLE.
- IDLE: req_ready=1. On accept, latch req_write, req_addr → mem_addr, req_wdata → mem_wr_data (writes only). Go to STROBE.
- STROBE: mem_rd_mem=1 for a read, mem_wr_mem=1 for a write, exactly one cycle. Clear wait counter. Go to WAIT.
- WAIT: a matching done (rd_done for reads, wr_done for writes) captures the result: read → rsp_rdata=mem_rd_data; write → rsp_rdata=0; rsp_err=0. Go to RESP. A non-matching done is ignored. Otherwise the counter increments.
- RESP: rsp_valid=1 and rsp_rdata/rsp_err are stable until rsp_ready=1. Then go to IDLE.
- req_ready=1 only in IDLE. Only one outstanding transaction.
- mem_addr and mem_wr_data hold their values from STROBE through RESP and keep their last value in IDLE.
- Done inputs are ignored in IDLE, STROBE and RESP.
- Reset values (also forced on any rst_n=0 edge, including mid-transaction): state IDLE, mem_rd_mem=0, mem_wr_mem=0, mem_addr=0, mem_wr_data=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0.
- A done arriving after a mid-transaction reset is ignored.

## Timing
- Accept at edge of cycle N. Strobe is high in cycle N+1. WAIT starts in cycle N+2.
- Done seen in WAIT cycle D → rsp_valid in cycle D+1.
- Minimum latency: done in N+2 → rsp_valid in N+3. A new request can be accepted in the cycle after the response handshake.
- Strobes are registered outputs. req_ready and rsp_valid decode from the state register.
- Counter width is $clog2(TIMEOUT+1).

## Configuration
- VME_MASTER_TIMEOUT_EN defined:
  - Timeout fires when TIMEOUT WAIT cycles pass with no matching done. The last WAIT cycle is the one where counter == TIMEOUT-1.
  - On timeout: rsp_err=1, rsp_rdata=0, go to RESP.
  - A matching done in the expiry cycle wins (err=0).
- VME_MASTER_TIMEOUT_EN undefined: no counter, WAIT lasts until a matching done arrives, rsp_err is tied 0, TIMEOUT is unused.

## Test plan
- Read addr 0x02; responder asserts rd_done with 0xBEEF one cycle after the strobe → single-cycle mem_rd_mem with mem_addr=0x02; rsp_valid 3 cycles after accept; rsp_rdata=0xBEEF, rsp_err=0.
- Write 0x1234 to addr 0x00; wr_done two cycles after the strobe → single-cycle mem_wr_mem with mem_wr_data=0x1234; rsp_rdata=0, rsp_err=0; mem_wr_data stable until the response handshake.
- TIMEOUT_EN, TIMEOUT=4, read with no done → rsp_err=1 and rsp_rdata=0 after 4 WAIT cycles. Repeat with rd_done in the 4th WAIT cycle → rsp_err=0 with the data.
- Response back-pressure: rsp_ready low for 5 cycles → rsp_valid, rsp_rdata and rsp_err held; req_ready=0; no new strobe despite req_valid=1. Next request is accepted the cycle after rsp_ready=1.
- Reset in the WAIT cycle, then rd_done 2 cycles later → strobes 0, rsp_valid 0, the late done produces no response. The next read completes normally.
- Wrong-type done: wr_done pulse during a pending read → ignored; the read completes only on rd_done.
